fetch_cycle: RTL
================

Name: fetch_cycle

Overview:
- Instruction-fetch stage of the 5-stage pipeline, directly upstream of the instruction memory.
- Owns the program counter (PCF) and drives it as the word-address source for the combinational instruction memory.
- Captures the returned instruction into the IF/ID pipeline register for the decode stage.
- Handles sequential PC+4 flow, execute-stage branch/jump redirect, hazard-unit stalls and decode flushes.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset.
- NOP_INSTR, 32'h00000013, bubble inserted into IF/ID (addi x0,x0,0).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- PCSrcE  input  1  redirect request from EX (taken branch/jump).
- PCTargetE  input  32  redirect target from EX.
- StallF  input  1  hold PCF (hazard unit).
- StallD  input  1  hold IF/ID contents (hazard unit).
- FlushD  input  1  squash IF/ID (hazard unit).
- imem_rdata  input  32  instruction returned by instruction memory for imem_addr (same cycle).
- imem_addr  output  32  fetch address, equals PCF.
- InstrD  output  32  IF/ID instruction.
- PCD  output  32  IF/ID PC of InstrD.
- PCPlus4D  output  32  IF/ID PC+4 of InstrD.
- ValidD  output  1  IF/ID holds a real fetched instruction.
- FetchCount  output  32  count of valid instructions loaded into IF/ID.

Behaviour:
- Reset (rst=0, asynchronous, effective immediately including mid-operation):
  - PCF=RESET_PC, InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, ValidD=0, FetchCount=0.
  - Instruction memory returns 0 during reset; nothing is captured while rst=0.
- imem_addr = PCF, combinational. PCPlus4F = PCF+32'd4, modulo 2^32 (0xFFFFFFFC wraps to 0).
- Next PCF at each rising edge, priority high to low:
  1. PCSrcE=1 -> {PCTargetE[31:2],2'b00}. Low bits are forced to zero. Redirect overrides StallF.
  2. StallF=1 -> PCF holds.
  3. Otherwise -> PCPlus4F.
- IF/ID update at each rising edge, priority high to low:
  1. FlushD=1 or PCSrcE=1 -> InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, ValidD=0. Redirect self-flushes the wrong-path fetch.
  2. StallD=1 -> all IF/ID fields hold, including ValidD.
  3. Otherwise -> InstrD=imem_rdata, PCD=PCF, PCPlus4D=PCPlus4F, ValidD=1.
- FetchCount increments by 1 on every edge taking IF/ID case 3. Wraps 0xFFFFFFFF->0. Unchanged on flush or stall.
- Latency:
  - Instruction at address A appears on InstrD one cycle after PCF=A.
  - After a redirect edge, the first target instruction appears on InstrD one cycle later. Exactly one bubble, from the self-flush.
- Reset release: first edge with rst=1 loads mem[RESET_PC>>2] into IF/ID (ValidD=1) and PCF becomes RESET_PC+4.
- StallF=1 with StallD=0 and no flush: IF/ID reloads the same PCF instruction. Legal, duplicates are expected to be handled by the hazard unit.
- StallD=1 with StallF=0: PC advances and that fetch is lost. The hazard unit never issues this combination; no internal protection.
- No X propagation: all registers have reset values; no latches.

Test Plan:
- Reset then release, memory word i = 0x100+i, no stalls/flushes -> InstrD sequence 0x100,0x101,0x102 on consecutive cycles; PCD 0,4,8; PCPlus4D 4,8,12; FetchCount=3 after 3 edges.
- Assert StallF=StallD=1 for 2 cycles at PCF=8 -> PCF stays 8, InstrD stays 0x101, FetchCount frozen; on release InstrD=0x102, PCD=8.
- PCSrcE=1, PCTargetE=0x40 for one cycle at PCF=0x10 -> next cycle PCF=0x40, ValidD=0, InstrD=0x00000013; following cycle InstrD=mem[16], PCD=0x40.
- PCSrcE=1 with StallF=1 and PCTargetE=0x43 -> PCF=0x40, IF/ID flushed.
- PCF=0xFFFFFFFC, no stall -> next PCF=0, PCPlus4D=0; FetchCount at 0xFFFFFFFF wraps to 0.
- Drop rst mid-run between edges -> all outputs take reset values immediately, without waiting for a clock edge; the first post-release fetch is from RESET_PC.

Source files
------------

// File: rtl/fetch_cycle_if.sv
// Fetch-stage bus: hazard/redirect controls in, instruction memory port, IF/ID register out.
interface fetch_cycle_if;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        StallF;
    logic        StallD;
    logic        FlushD;
    logic [31:0] imem_rdata;
    logic [31:0] imem_addr;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic        ValidD;
    logic [31:0] FetchCount;

    modport slave (
        input  PCSrcE, PCTargetE, StallF, StallD, FlushD, imem_rdata,
        output imem_addr, InstrD, PCD, PCPlus4D, ValidD, FetchCount
    );

    modport master (
        output PCSrcE, PCTargetE, StallF, StallD, FlushD, imem_rdata,
        input  imem_addr, InstrD, PCD, PCPlus4D, ValidD, FetchCount
    );
endinterface

// File: rtl/fetch_cycle.sv
// Instruction-fetch stage: owns PCF, addresses the combinational imem and fills the IF/ID register.
module fetch_cycle #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic          clk,
    input  logic          rst,
    fetch_cycle_if.slave  bus
);
    localparam int unsigned XLEN = 32;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic            valid;
    } ifid_t;

    logic [XLEN-1:0] pcf_q, pcf_d;
    logic [XLEN-1:0] pc_plus4_f;
    logic [XLEN-1:0] fetch_count_q, fetch_count_d;
    ifid_t           ifid_q, ifid_d;
    ifid_t           ifid_bubble;

    assign ifid_bubble = '{instr: NOP_INSTR, pc: '0, pc_plus4: '0, valid: 1'b0};

    // Next PC: redirect beats stall; target is forced word-aligned.
    always_comb begin
        pc_plus4_f = pcf_q + XLEN'(4);
        pcf_d      = pc_plus4_f;
        if (bus.PCSrcE) begin
            pcf_d = bus.PCTargetE & ~XLEN'(3);
        end else if (bus.StallF) begin
            pcf_d = pcf_q;
        end
    end

    // IF/ID: a redirect squashes the wrong-path fetch in the same edge as a decode flush.
    always_comb begin
        ifid_d        = ifid_q;
        fetch_count_d = fetch_count_q;
        if (bus.FlushD || bus.PCSrcE) begin
            ifid_d = ifid_bubble;
        end else if (!bus.StallD) begin
            ifid_d        = '{instr: bus.imem_rdata, pc: pcf_q, pc_plus4: pc_plus4_f, valid: 1'b1};
            fetch_count_d = fetch_count_q + XLEN'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pcf_q         <= RESET_PC;
            ifid_q        <= ifid_bubble;
            fetch_count_q <= '0;
        end else begin
            pcf_q         <= pcf_d;
            ifid_q        <= ifid_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign bus.imem_addr  = pcf_q;
    assign bus.InstrD     = ifid_q.instr;
    assign bus.PCD        = ifid_q.pc;
    assign bus.PCPlus4D   = ifid_q.pc_plus4;
    assign bus.ValidD     = ifid_q.valid;
    assign bus.FetchCount = fetch_count_q;
endmodule
